// File: rtl/bsg_fifos_credit_rr_arbiter.sv
// Credit-gated round-robin arbiter: per-slot FIFO heads compete for one registered
// output stage; every grant spends one downstream credit of the winning slot.
module bsg_fifos_credit_rr_arbiter #(
    parameter int num_slots_p = 4,
    parameter int width_p     = 32,
    parameter int credits_p   = 2,
    localparam int slot_w_lp  = (num_slots_p > 1) ? $clog2(num_slots_p) : 1,
    localparam int cred_w_lp  = $clog2(credits_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_slots_p-1:0]         slot_v_i,
    input  logic [num_slots_p*width_p-1:0] slot_data_i,
    output logic [num_slots_p-1:0]         slot_yumi_o,
    input  logic [num_slots_p-1:0]         slot_en_i,
    output logic                           out_v_o,
    output logic [width_p-1:0]             out_data_o,
    output logic [slot_w_lp-1:0]           out_slot_o,
    input  logic                           out_ready_i,
    input  logic [num_slots_p-1:0]         credit_return_i,
    output logic [num_slots_p*32-1:0]      credits_o
);

    localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(credits_p);
    localparam logic [cred_w_lp-1:0] cred_one_lp = cred_w_lp'(1);

    logic [cred_w_lp-1:0]   credit_q [num_slots_p];
    logic [cred_w_lp-1:0]   credit_d [num_slots_p];
    logic [slot_w_lp-1:0]   last_q, last_d;
    logic                   out_v_q, out_v_d;
    logic [width_p-1:0]     out_data_q, out_data_d;
    logic [slot_w_lp-1:0]   out_slot_q, out_slot_d;

    logic [num_slots_p-1:0] eligible;
    logic [num_slots_p-1:0] grant;
    logic [slot_w_lp-1:0]   winner;
    logic [width_p-1:0]     winner_data;
    logic                   found;
    logic                   stage_free;
    logic                   grant_v;
    int                     idx;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            eligible[i] = slot_v_i[i] & slot_en_i[i] & (credit_q[i] != '0);
        end
    end

    // Scan starting just past the last winner; ineligible slots are simply passed over.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= num_slots_p; k++) begin
            idx = int'(last_q) + k;
            if (idx >= num_slots_p) begin
                idx = idx - num_slots_p;
            end
            if (!found && eligible[slot_w_lp'(idx)]) begin
                found  = 1'b1;
                winner = slot_w_lp'(idx);
            end
        end
    end

    always_comb begin
        winner_data = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            if (slot_w_lp'(i) == winner) begin
                winner_data = slot_data_i[i*width_p +: width_p];
            end
        end
    end

    assign stage_free  = ~out_v_q | out_ready_i;
    assign grant_v     = stage_free & found & ~reset_i;
    assign grant       = grant_v ? ({{(num_slots_p-1){1'b0}}, 1'b1} << winner) : '0;
    assign slot_yumi_o = grant;

    always_comb begin
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
        out_slot_d = out_slot_q;
        last_d     = last_q;
        if (grant_v) begin
            out_v_d    = 1'b1;
            out_data_d = winner_data;
            out_slot_d = winner;
            last_d     = winner;
        end else if (out_ready_i) begin
            out_v_d = 1'b0;
        end
    end

    // A return arriving while already full is dropped, keeping the count saturated.
    always_comb begin
        for (int i = 0; i < num_slots_p; i++) begin
            credit_d[i] = credit_q[i];
            if (grant[i] && !credit_return_i[i]) begin
                credit_d[i] = credit_q[i] - cred_one_lp;
            end else if (!grant[i] && credit_return_i[i] && (credit_q[i] != cred_max_lp)) begin
                credit_d[i] = credit_q[i] + cred_one_lp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_slot_q <= '0;
            last_q     <= slot_w_lp'(num_slots_p - 1);
            for (int i = 0; i < num_slots_p; i++) begin
                credit_q[i] <= cred_max_lp;
            end
        end else begin
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_slot_q <= out_slot_d;
            last_q     <= last_d;
            for (int i = 0; i < num_slots_p; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < num_slots_p; i++) begin
                assert (!(credit_return_i[i] && !grant[i] && (credit_q[i] == cred_max_lp)))
                    else $error("credit return overflow on slot %0d", i);
            end
        end
    end

    always_comb begin
        credits_o = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            credits_o[i*32 +: 32] = 32'(credit_q[i]);
        end
    end

    assign out_v_o    = out_v_q;
    assign out_data_o = out_data_q;
    assign out_slot_o = out_slot_q;

endmodule
